// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
//
// Purpose:
//   Shares one single-ported unified instruction/data memory between the IF
//   stage fetch port and the MEM stage load/store port. One requester is
//   granted at a time. The arbiter drives a variable-latency memory handshake
//   and returns read data plus a one-cycle acknowledge to the granted port.
//   Data accesses win arbitration. A starvation counter forces a fetch grant
//   after STARVE_MAX consecutive data grants taken while fetch was waiting.
//
// Ports:
//   clk, rst                 clock; asynchronous active-low reset
//   if_req/if_addr           fetch request (held until if_ack) and address
//   if_ack/if_rdata          fetch complete strobe and instruction word
//   if_stall                 if_req & ~if_ack
//   d_req/d_we/d_addr/
//   d_wdata/d_be             load/store request and attributes
//   d_ack/d_rdata            data complete strobe and load data
//   d_stall                  d_req & ~d_ack
//   m_req                    memory access in progress
//   m_we/m_addr/m_wdata/m_be registered attributes of the current access
//   m_rdata/m_ready          memory read data, valid with m_ready
//   busy                     arbiter is not idle
// -----------------------------------------------------------------------------
module mem_port_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic                clk,
  input  logic                rst,

  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic                if_ack,
  output logic [DATA_W-1:0]   if_rdata,
  output logic                if_stall,

  input  logic                d_req,
  input  logic                d_we,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  input  logic [DATA_W/8-1:0] d_be,
  output logic                d_ack,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                d_stall,

  output logic                m_req,
  output logic                m_we,
  output logic [ADDR_W-1:0]   m_addr,
  output logic [DATA_W-1:0]   m_wdata,
  output logic [DATA_W/8-1:0] m_be,
  input  logic [DATA_W-1:0]   m_rdata,
  input  logic                m_ready,

  output logic                busy
);

  localparam int BE_W  = DATA_W / 8;
  localparam int CNT_W = $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY_IF = 2'd1,
    BUSY_D  = 2'd2
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [CNT_W-1:0] starve_cnt;
  logic [CNT_W-1:0] starve_cnt_next;
  logic             fetch_starved;
  logic             grant_if;
  logic             grant_d;

  // ---------------------------------------------------------------------------
  // State and starvation counter registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      starve_cnt <= '0;
    end else begin
      state      <= state_next;
      starve_cnt <= starve_cnt_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state, arbitration and acknowledge logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next      = state;
    starve_cnt_next = starve_cnt;
    grant_if        = 1'b0;
    grant_d         = 1'b0;
    if_ack          = 1'b0;
    d_ack           = 1'b0;
    fetch_starved   = (starve_cnt == CNT_MAX);

    case (state)
      IDLE: begin
        // Data has priority unless fetch has already waited through
        // STARVE_MAX data grants.
        if (d_req && !(if_req && fetch_starved)) begin
          grant_d = 1'b1;
        end else if (if_req) begin
          grant_if = 1'b1;
        end

        if (grant_d) begin
          state_next = BUSY_D;
        end else if (grant_if) begin
          state_next = BUSY_IF;
        end

        // Only data grants that overtake a waiting fetch count toward
        // starvation; an idle fetch port or a fetch grant resets the count.
        if (grant_if || !if_req) begin
          starve_cnt_next = '0;
        end else if (grant_d && !fetch_starved) begin
          starve_cnt_next = starve_cnt + CNT_W'(1);
        end
      end

      BUSY_IF: begin
        if (m_ready) begin
          if_ack     = 1'b1;
          state_next = IDLE;
        end
      end

      BUSY_D: begin
        if (m_ready) begin
          d_ack      = 1'b1;
          state_next = IDLE;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Access attribute registers: loaded only on a grant, so requester-side
  // changes during an access do not reach the memory.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_we    <= 1'b0;
      m_addr  <= '0;
      m_wdata <= '0;
      m_be    <= '0;
    end else if (grant_d) begin
      m_we    <= d_we;
      m_addr  <= d_addr;
      m_wdata <= d_wdata;
      m_be    <= d_be;
    end else if (grant_if) begin
      m_we    <= 1'b0;
      m_addr  <= if_addr;
      m_wdata <= '0;
      m_be    <= {BE_W{1'b0}};
    end
  end

  // ---------------------------------------------------------------------------
  // Output decode
  // ---------------------------------------------------------------------------
  assign m_req    = (state != IDLE);
  assign busy     = (state != IDLE);

  // Read data is steered only to the port being acknowledged.
  assign if_rdata = if_ack ? m_rdata : '0;
  assign d_rdata  = d_ack  ? m_rdata : '0;

  assign if_stall = if_req & ~if_ack;
  assign d_stall  = d_req  & ~d_ack;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_port_arbiter
//
// Purpose:
//   Self-checking bench for mem_port_arbiter. A transaction-level model tracks
//   which port owns the memory, the attributes latched at the grant and the
//   starvation count, and predicts every output each cycle. Directed tests pin
//   the model with literal expectations. A small memory responder raises
//   m_ready after a programmable number of busy cycles.
// -----------------------------------------------------------------------------
module tb_mem_port_arbiter;

  localparam int ADDR_W     = 32;
  localparam int DATA_W     = 32;
  localparam int STARVE_MAX = 4;

  logic              clk;
  logic              rst;
  logic              if_req;
  logic [31:0]       if_addr;
  logic              if_ack;
  logic [31:0]       if_rdata;
  logic              if_stall;
  logic              d_req;
  logic              d_we;
  logic [31:0]       d_addr;
  logic [31:0]       d_wdata;
  logic [3:0]        d_be;
  logic              d_ack;
  logic [31:0]       d_rdata;
  logic              d_stall;
  logic              m_req;
  logic              m_we;
  logic [31:0]       m_addr;
  logic [31:0]       m_wdata;
  logic [3:0]        m_be;
  logic [31:0]       m_rdata;
  logic              m_ready;
  logic              busy;

  int checks = 0;
  int errors = 0;

  mem_port_arbiter #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W),
    .STARVE_MAX(STARVE_MAX)
  ) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack),
    .if_rdata(if_rdata), .if_stall(if_stall),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_be(d_be), .d_ack(d_ack), .d_rdata(d_rdata), .d_stall(d_stall),
    .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_be(m_be), .m_rdata(m_rdata), .m_ready(m_ready), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural model: owner 0 = none, 1 = fetch, 2 = data
  // ---------------------------------------------------------------------------
  int          mdl_owner  = 0;
  logic [31:0] mdl_addr   = '0;
  logic [31:0] mdl_wdata  = '0;
  logic        mdl_we     = 1'b0;
  logic [3:0]  mdl_be     = '0;
  int          mdl_starve = 0;
  byte         glog[$];

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      mdl_owner = 0; mdl_addr = '0; mdl_wdata = '0; mdl_we = 1'b0;
      mdl_be = '0; mdl_starve = 0;
    end else if (mdl_owner == 0) begin
      if (d_req && !(if_req && mdl_starve == STARVE_MAX)) begin
        mdl_owner = 2; mdl_addr = d_addr; mdl_we = d_we;
        mdl_wdata = d_wdata; mdl_be = d_be;
        glog.push_back("D");
        if (if_req) mdl_starve = (mdl_starve < STARVE_MAX) ? mdl_starve + 1 : STARVE_MAX;
        else        mdl_starve = 0;
      end else if (if_req) begin
        mdl_owner = 1; mdl_addr = if_addr; mdl_we = 1'b0; mdl_be = '0;
        mdl_starve = 0;
        glog.push_back("I");
      end else begin
        mdl_starve = 0;
      end
    end else if (m_ready) begin
      mdl_owner = 0;
    end
  end

  // ---------------------------------------------------------------------------
  // Memory responder: m_ready in the lat-th busy cycle, or in idle when spur=1
  // ---------------------------------------------------------------------------
  int          lat = 1;
  int          bc = 0;
  logic        spur = 1'b0;
  logic        fixed_en = 1'b0;
  logic [31:0] fixed_data = '0;

  initial begin
    m_ready = 1'b0;
    m_rdata = '0;
    forever begin
      @(posedge clk);
      #1;
      if (!rst || mdl_owner == 0) bc = 0;
      else bc++;
      m_ready = (mdl_owner != 0 && bc == lat) || (mdl_owner == 0 && spur);
      m_rdata = fixed_en ? fixed_data : (mdl_addr ^ 32'hC0DE_0000 ^ 32'(bc));
    end
  end

  // ---------------------------------------------------------------------------
  // Per-cycle compare against the model
  // ---------------------------------------------------------------------------
  always @(negedge clk) begin
    logic ea_if;
    logic ea_d;
    ea_if = (mdl_owner == 1) && m_ready;
    ea_d  = (mdl_owner == 2) && m_ready;
    chk("m_req", m_req, mdl_owner != 0);
    chk("busy", busy, mdl_owner != 0);
    chk("if_ack", if_ack, ea_if);
    chk("d_ack", d_ack, ea_d);
    chk("if_rdata", if_rdata, ea_if ? m_rdata : 32'h0);
    chk("d_rdata", d_rdata, ea_d ? m_rdata : 32'h0);
    chk("if_stall", if_stall, if_req && !ea_if);
    chk("d_stall", d_stall, d_req && !ea_d);
    chk("starve_cnt", dut.starve_cnt, mdl_starve);
    if (mdl_owner != 0) begin
      chk("m_addr", m_addr, mdl_addr);
      chk("m_we", m_we, mdl_we);
      chk("m_be", m_be, mdl_be);
      if (mdl_owner == 2) chk("m_wdata", m_wdata, mdl_wdata);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------------
  // Directed stimulus
  // ---------------------------------------------------------------------------
  initial begin
    int stall_cnt;
    int stable_cnt;
    int ack_cnt;
    bit done;
    string seq;

    rst = 1'b0;
    if_req = 1'b0; if_addr = '0;
    d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0; d_be = '0;

    @(negedge clk);
    chk("reset_busy", busy, 1'b0);
    chk("reset_m_req", m_req, 1'b0);
    chk("reset_m_addr", m_addr, 32'h0);
    #2 rst = 1'b1;

    // Single fetch, memory ready in the first busy cycle
    lat = 1; fixed_en = 1'b1; fixed_data = 32'h0050_0093;
    @(posedge clk); #1;
    if_req = 1'b1; if_addr = 32'h10;
    @(negedge clk);
    chk("fetch_c0_stall", if_stall, 1'b1);
    @(negedge clk);
    chk("fetch_c1_m_req", m_req, 1'b1);
    chk("fetch_c1_m_addr", m_addr, 32'h10);
    chk("fetch_c1_m_we", m_we, 1'b0);
    chk("fetch_c1_ack", if_ack, 1'b1);
    chk("fetch_c1_rdata", if_rdata, 32'h0050_0093);
    @(posedge clk); #1;
    if_req = 1'b0;
    @(negedge clk);
    chk("fetch_c2_busy", busy, 1'b0);
    fixed_en = 1'b0;

    // Store with three busy cycles
    lat = 3; stall_cnt = 0; stable_cnt = 0; ack_cnt = 0; done = 0;
    @(posedge clk); #1;
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h30; d_wdata = 32'hA; d_be = 4'hF;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk);
      if (d_stall) stall_cnt++;
      if (busy && m_addr == 32'h30 && m_we && m_wdata == 32'hA && m_be == 4'hF) stable_cnt++;
      if (d_ack) begin ack_cnt++; done = 1; end
      // attribute changes after the grant must not reach the memory
      if (busy) d_addr = 32'h3C;
    end
    chk("store_done", done, 1'b1);
    chk("store_stall_cycles", stall_cnt, 3);
    chk("store_stable_cycles", stable_cnt, 3);
    chk("store_ack_count", ack_cnt, 1);
    @(posedge clk); #1;
    d_req = 1'b0; d_we = 1'b0;
    @(negedge clk);
    chk("store_ack_one_cycle", d_ack, 1'b0);
    chk("store_idle_after", busy, 1'b0);

    // Spurious ready in idle
    spur = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("spur_no_ack", {if_ack, d_ack}, 2'b00);
      chk("spur_idle", busy, 1'b0);
    end
    spur = 1'b0;

    // Continuous contention
    glog.delete();
    lat = 1; done = 0;
    @(posedge clk); #1;
    if_req = 1'b1; if_addr = 32'h100;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h200;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk);
      if (if_ack) chk("contention_starve_clear", dut.starve_cnt, 0);
      if (glog.size() >= 10 && (if_ack || d_ack)) done = 1;
    end
    chk("contention_done", done, 1'b1);
    @(posedge clk); #1;
    if_req = 1'b0; d_req = 1'b0;
    seq = "";
    for (int i = 0; i < 10 && i < glog.size(); i++) seq = $sformatf("%s%c", seq, glog[i]);
    checks++;
    if (seq != "DDDDIDDDDI") begin
      errors++;
      $display("FAIL contention_order: got %s expected DDDDIDDDDI", seq);
    end
    repeat (2) @(negedge clk);

    // Priority without starvation
    lat = 2; done = 0;
    @(posedge clk); #1;
    if_req = 1'b1; if_addr = 32'h44;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h88;
    @(negedge clk);
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk);
      chk("prio_d_first", if_ack, 1'b0);
      chk("prio_starve_during_d", dut.starve_cnt, 1);
      if (d_ack) done = 1;
    end
    chk("prio_d_done", done, 1'b1);
    @(posedge clk); #1;
    d_req = 1'b0;
    @(negedge clk);
    chk("prio_if_wait_starve", dut.starve_cnt, 1);
    chk("prio_if_wait_stall", if_stall, 1'b1);
    done = 0;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk);
      if (if_ack) begin
        done = 1;
        chk("prio_if_addr", m_addr, 32'h44);
        chk("prio_starve_after_if", dut.starve_cnt, 0);
      end
    end
    chk("prio_if_done", done, 1'b1);
    @(posedge clk); #1;
    if_req = 1'b0;
    @(negedge clk);

    // Asynchronous reset in the middle of a data access
    lat = 100;
    @(posedge clk); #1;
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h60; d_wdata = 32'h5; d_be = 4'h3;
    @(negedge clk);
    @(negedge clk);
    chk("rst_pre_busy", busy, 1'b1);
    @(posedge clk); #3;
    rst = 1'b0;
    #1;
    chk("rst_m_req", m_req, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_d_ack", d_ack, 1'b0);
    chk("rst_m_addr", m_addr, 32'h0);
    chk("rst_d_stall", d_stall, 1'b1);
    @(negedge clk);
    d_req = 1'b0; d_we = 1'b0;
    #2 rst = 1'b1;
    lat = 1; ack_cnt = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (d_ack || if_ack) ack_cnt++;
      chk("rst_after_idle", busy, 1'b0);
    end
    chk("rst_no_ack", ack_cnt, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Sequential arbiter that shares one single-ported unified instruction/data memory between the pipeline's IF stage fetch port and MEM stage load/store port. It grants one requester at a time and drives a variable-latency memory handshake. It returns read data and a one-cycle acknowledge to the granted port, and produces stall signals for the pipeline control logic. Data accesses have priority, and a starvation counter guarantees forward progress for fetch.

## Interface

- ADDR_W, 32, address width of both ports and the memory
- DATA_W, 32, data width
- STARVE_MAX, 4, consecutive data grants allowed while fetch is waiting; fetch then wins the next arbitration
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  asynchronous, active-low reset
- if_req  in  1  fetch request; held until if_ack
- if_addr  in  ADDR_W  fetch address
- if_ack  out  1  fetch complete; if_rdata valid this cycle
- if_rdata  out  DATA_W  fetched instruction
- if_stall  out  1  if_req & ~if_ack
- d_req  in  1  load/store request; held until d_ack
- d_we  in  1  1 = store, 0 = load
- d_addr  in  ADDR_W  data address
- d_wdata  in  DATA_W  store data
- d_be  in  DATA_W/8  store byte enables
- d_ack  out  1  data access complete; d_rdata valid this cycle for loads
- d_rdata  out  DATA_W  load data
- d_stall  out  1  d_req & ~d_ack
- m_req  out  1  memory access in progress
- m_we, m_addr, m_wdata, m_be  out  1 / ADDR_W / DATA_W / DATA_W/8  registered access attributes
- m_rdata  in  DATA_W  memory read data, valid with m_ready
- m_ready  in  1  memory completes the current access this cycle
- busy  out  1  state != IDLE

## Operation

- States are IDLE, BUSY_IF and BUSY_D.
- **IDLE**
  - Only d_req: go to BUSY_D.
  - Only if_req: go to BUSY_IF.
  - Both requests: go to BUSY_D, unless starve_cnt == STARVE_MAX, in which case go to BUSY_IF.
  - On every transition, latch the winner's attributes into m_addr/m_we/m_wdata/m_be. For fetch, m_we=0 and m_be=0.
- **BUSY_x**
  - m_req=1.
  - When m_ready=1, x_ack=1 combinationally, x_rdata=m_rdata, and next state is IDLE.
  - Otherwise the arbiter holds the state and all m_* outputs.
- **Non-granted ports:** ack=0, and rdata is driven as 0.
- **starve_cnt**
  - Width is $clog2(STARVE_MAX+1).
  - Increments on a D grant made while if_req=1, saturating at STARVE_MAX.
  - Clears on any IF grant, or at any IDLE cycle where if_req=0.
- **Attribute changes:** attributes that change after the grant are ignored. The requester must hold req until ack, then drop it or present a new request at the next edge.
- **m_ready outside an access:** m_ready in IDLE is ignored.

## Timing

- **Reset (rst=0, asynchronous):**
  - State goes to IDLE and starve_cnt to 0.
  - All outputs go to 0: m_req, m_we, m_addr, m_wdata, m_be, if_ack, d_ack, if_rdata, d_rdata, busy. The stalls follow their equations, so they show if_req/d_req.
  - An in-flight access is abandoned with no ack; the memory is reset with it.
- **Latency:**
  - A request in IDLE at edge k gives m_req=1 from cycle k+1.
  - The earliest ack is in cycle k+1, if m_ready=1 in the first busy cycle. Minimum throughput is one access per 2 cycles.
  - With memory latency L (m_ready in the L-th busy cycle), the ack comes L cycles after the grant edge.
- **Back-to-back:** the ack cycle is followed by IDLE. A request still pending then is arbitrated at that cycle's edge, so there is exactly one IDLE cycle between accesses.
- **Simultaneous requests:** the loser's stall stays high through the whole winner access plus the re-arbitration cycle.
- **Starvation bound:** with both requesting continuously, the grant order is D×STARVE_MAX, then IF, then repeats.
- **Stall timing:** if_stall/d_stall are combinational and deassert in the ack cycle.

## Test plan

- **Reset:** rst=0 mid-BUSY_D with m_ready=0, asserted asynchronously between edges → m_req, busy, d_ack and m_addr are 0 immediately; after release, state is IDLE and no ack is issued.
- **Single fetch:** if_req with if_addr=0x10, m_ready=1 in the first busy cycle, m_rdata=0x00500093 → m_req=1, m_addr=0x10 and m_we=0 in cycle 1; if_ack=1 and if_rdata=0x00500093 in cycle 1; busy=0 in cycle 2.
- **Store with wait states:** d_req, d_we=1, d_addr=0x30, d_wdata=0xA, d_be=0xF, m_ready after 3 busy cycles → m_* stable for 3 cycles; d_ack for one cycle; d_stall high until the ack cycle.
- **Contention:** if_req and d_req both held continuously, m_ready=1 always → grant sequence D,D,D,D,IF,D,D,D,D,IF; starve_cnt returns to 0 after each IF grant.
- **Priority without starvation:** both request once, then if_req only → D is served first, IF second; starve_cnt=1 during the IF wait and 0 after.
- **Spurious ready:** m_ready=1 in IDLE with no requests → no ack, no state change.
